reg_writeback_unit: RTL

- Producer side of the processor register file's write port, plus the scoreboard decode consults before reading it.
- Tracks destination registers with results in flight and flags RAW/WAW hazards to decode.
- Accepts results from the single-cycle ALU and a multi-cycle multiplier; buffers and arbitrates them onto the single write port (wrEnable/wrNum/wrData).

---
 rtl/reg_writeback_unit_pkg.sv | 14 +
 rtl/reg_writeback_unit_if.sv | 47 ++++
 rtl/reg_writeback_unit_result_fifo.sv | 54 +++++
 rtl/reg_writeback_unit.sv | 95 +++++++++
 4 files changed

// File: rtl/reg_writeback_unit_pkg.sv
// Shared widths and the buffered-result entry type for the register writeback unit.
package reg_writeback_unit_pkg;
  localparam int DATA_WIDTH    = 32;
  localparam int REG_NUM_WIDTH = 5;
  localparam int REG_FILE_SIZE = 2 ** REG_NUM_WIDTH;

  typedef logic [REG_NUM_WIDTH-1:0] reg_num_t;
  typedef logic [DATA_WIDTH-1:0]    data_t;

  typedef struct packed {
    reg_num_t dst;
    data_t    data;
  } wb_entry_t;
endpackage

// File: rtl/reg_writeback_unit_if.sv
// Decode / ALU / multiplier / register-file write port bundle.
// REG_WRITEBACK_FORWARD_EN adds the forwarding select and data signals.
interface reg_writeback_unit_if;
  import reg_writeback_unit_pkg::*;

  logic     issueValid;
  reg_num_t issueDst;
  reg_num_t srcNumA;
  reg_num_t srcNumB;
  logic     hazard;
  logic     aluValid;
  reg_num_t aluDst;
  data_t    aluData;
  logic     mulValid;
  logic     mulReady;
  reg_num_t mulDst;
  data_t    mulData;
  logic     wrEnable;
  reg_num_t wrNum;
  data_t    wrData;
  logic     idle;
`ifdef REG_WRITEBACK_FORWARD_EN
  logic     fwdSelA;
  logic     fwdSelB;
  data_t    fwdData;
`endif

  modport slave (
    input  issueValid, issueDst, srcNumA, srcNumB,
    input  aluValid, aluDst, aluData,
    input  mulValid, mulDst, mulData,
    output hazard, mulReady, wrEnable, wrNum, wrData, idle
`ifdef REG_WRITEBACK_FORWARD_EN
    , output fwdSelA, fwdSelB, fwdData
`endif
  );

  modport master (
    output issueValid, issueDst, srcNumA, srcNumB,
    output aluValid, aluDst, aluData,
    output mulValid, mulDst, mulData,
    input  hazard, mulReady, wrEnable, wrNum, wrData, idle
`ifdef REG_WRITEBACK_FORWARD_EN
    , input fwdSelA, fwdSelB, fwdData
`endif
  );
endinterface

// File: rtl/reg_writeback_unit_result_fifo.sv
// wb_result_fifo: small circular buffer of multiplier results waiting for the write port.
module wb_result_fifo
  import reg_writeback_unit_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic      clk,
  input  logic      rstN,
  input  logic      push_i,
  input  wb_entry_t din_i,
  input  logic      pop_i,
  output wb_entry_t dout_o,
  output logic      full_o,
  output logic      empty_o
);
  localparam int PW = $clog2(DEPTH);

  wb_entry_t       mem_q [DEPTH];
  logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [PW:0]     cnt_q, cnt_d;
  logic            push_ok, pop_ok;

  assign full_o  = (cnt_q == (PW+1)'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign dout_o  = mem_q[rd_ptr_q];
  assign push_ok = push_i & ~full_o;
  assign pop_ok  = pop_i & ~empty_o;

  always_comb begin
    cnt_d = cnt_q;
    case ({push_ok, pop_ok})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  // Power-of-two depth lets the pointers wrap by plain overflow.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      cnt_q <= cnt_d;
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= din_i;
  end
endmodule

// File: rtl/reg_writeback_unit.sv
// Register-file write port arbiter plus busy scoreboard for decode hazard checks.
// Optional REG_WRITEBACK_FORWARD_EN forwards the write-port data to decode sources.
module reg_writeback_unit
  import reg_writeback_unit_pkg::*;
#(
  parameter int BUF_DEPTH = 2
) (
  input logic                  clk,
  input logic                  rstN,
  reg_writeback_unit_if.slave  bus
);
  logic [REG_FILE_SIZE-1:0] busy_q, busy_d;
  logic      wr_en_q, wr_en_d;
  reg_num_t  wr_num_q, wr_num_d;
  data_t     wr_data_q, wr_data_d;
  logic      idle_q;

  wb_entry_t head, sel, mul_in;
  logic      sel_vld, fifo_full, fifo_empty, fifo_push, fifo_pop;
  logic      haz_a, haz_b, issue_ok;

  assign mul_in    = '{dst: bus.mulDst, data: bus.mulData};
  assign fifo_push = bus.mulValid & ~fifo_full;
  assign fifo_pop  = ~bus.aluValid & ~fifo_empty;

  wb_result_fifo #(.DEPTH(BUF_DEPTH)) u_fifo (
    .clk     (clk),
    .rstN    (rstN),
    .push_i  (fifo_push),
    .din_i   (mul_in),
    .pop_i   (fifo_pop),
    .dout_o  (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // Busy stays set through the write cycle; it drops at the edge that ends it.
`ifdef REG_WRITEBACK_FORWARD_EN
  logic fwd_a, fwd_b;
  assign fwd_a       = wr_en_q & (wr_num_q == bus.srcNumA) & (wr_num_q != '0);
  assign fwd_b       = wr_en_q & (wr_num_q == bus.srcNumB) & (wr_num_q != '0);
  assign haz_a       = busy_q[bus.srcNumA] & ~fwd_a;
  assign haz_b       = busy_q[bus.srcNumB] & ~fwd_b;
  assign bus.fwdSelA = fwd_a;
  assign bus.fwdSelB = fwd_b;
  assign bus.fwdData = wr_data_q;
`else
  assign haz_a = busy_q[bus.srcNumA];
  assign haz_b = busy_q[bus.srcNumB];
`endif

  assign bus.hazard   = haz_a | haz_b | (bus.issueValid & busy_q[bus.issueDst]);
  assign issue_ok     = bus.issueValid & ~bus.hazard;
  assign bus.mulReady = ~fifo_full;
  assign bus.wrEnable = wr_en_q;
  assign bus.wrNum    = wr_num_q;
  assign bus.wrData   = wr_data_q;
  assign bus.idle     = idle_q;

  // ALU owns the port whenever it has a result; the buffer drains in the gaps.
  always_comb begin
    sel_vld   = bus.aluValid | ~fifo_empty;
    sel       = bus.aluValid ? '{dst: bus.aluDst, data: bus.aluData} : head;
    wr_en_d   = sel_vld & (sel.dst != '0);
    wr_num_d  = wr_num_q;
    wr_data_d = wr_data_q;
    if (wr_en_d) begin
      wr_num_d  = sel.dst;
      wr_data_d = sel.data;
    end
  end

  always_comb begin
    busy_d = busy_q;
    if (wr_en_q)  busy_d[wr_num_q]     = 1'b0;
    if (issue_ok) busy_d[bus.issueDst] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      busy_q    <= '0;
      wr_en_q   <= 1'b0;
      wr_num_q  <= '0;
      wr_data_q <= '0;
      idle_q    <= 1'b1;
    end else begin
      busy_q    <= busy_d;
      wr_en_q   <= wr_en_d;
      wr_num_q  <= wr_num_d;
      wr_data_q <= wr_data_d;
      idle_q    <= (busy_q == '0) & fifo_empty;
    end
  end
endmodule
